dm_boot_sequencer: RTL and testbench
====================================

DM_BOOT_SEQUENCER -- requirements
Module: dm_boot_sequencer

Interface
REQ-001 The block SHALL have parameter BOOT_ADDR, default 32'h8000_0080, the value written to the hart's DPC before resume.
REQ-002 The block SHALL have parameter HARTSEL, default 10'd0, the hart index placed in dmcontrol hartsello[25:16]; hartselhi[15:6] = 0.
REQ-003 The block SHALL have parameter POLL_LIMIT, default 1024, the maximum reads per poll loop, used only when DM_BOOT_SEQ_TIMEOUT_EN is defined.
REQ-004 The block SHALL have these ports, clock and reset first:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle start pulse.
- image_ready_i  in  1  memory image loaded.
- dmi_req_valid_o  out  1  DMI request valid.
- dmi_req_ready_i  in  1  DMI request ready.
- dmi_req_addr_o  out  7  DMI request address.
- dmi_req_op_o  out  2  DMI op: 1 = read, 2 = write.
- dmi_req_data_o  out  32  DMI write data.
- dmi_resp_valid_i  in  1  DMI response valid.
- dmi_resp_ready_o  out  1  DMI response ready.
- dmi_resp_data_i  in  32  DMI response data.
- dmi_resp_i  in  2  DMI response code: 0 = ok, 2 = failed, 3 = busy.
- busy_o  out  1  sequence in progress.
- halted_o  out  1  hart confirmed halted, awaiting image.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  sticky error flag.
- err_code_o  out  3  error cause.

Function
REQ-005 The block SHALL leave IDLE only on start_i = 1; start_i SHALL be ignored while busy_o = 1.
REQ-006 The block SHALL execute these steps in order (hs = HARTSEL<<16):
- S1 write 0x10 = 0x1.
- S2 write 0x10 = hs|0x1.
- S3 write 0x10 = 0x8000_0000|hs|0x1.
- S4 poll read 0x11 until bit9 (allhalted) = 1.
- S5 write 0x10 = hs|0x1.
- S6 wait for image_ready_i = 1.
- S7 write 0x04 = BOOT_ADDR.
- S8 write 0x17 = 0x0023_07B1.
- S9 poll read 0x16 until bit12 (busy) = 0.
- S10 write 0x10 = 0x4000_0000|hs|0x1.
- S11 poll read 0x11 until bit17 (allresumeack) = 1.
- then DONE.
REQ-007 The block SHALL keep at most one DMI transaction outstanding: each step is an ISSUE state followed by a WAIT_RESP state.
REQ-008 The block SHALL hold dmi_req_valid_o and the request payload stable from assertion until the cycle dmi_req_ready_i = 1; valid SHALL deassert the cycle after acceptance.
REQ-009 The block SHALL drive dmi_resp_ready_o = 1 only in WAIT_RESP; a response SHALL be consumed when dmi_resp_valid_i & dmi_resp_ready_o.
REQ-010 On response code 3 (busy) the block SHALL reissue the same request; on code 2 (failed) it SHALL go to ERROR with err_code 1.
REQ-011 On S9, if the response has busy = 0 and cmderr[10:8] != 0, the block SHALL go to ERROR with err_code 3.
REQ-012 The block SHALL assert halted_o only during S5..S6; an image_ready_i already high on S6 entry SHALL proceed with zero extra wait.
REQ-013 The block SHALL pulse done_o for exactly one cycle on the DONE->IDLE transition; busy_o SHALL be 1 in every non-IDLE, non-ERROR state.
REQ-014 The block SHALL hold error_o = 1 and err_code_o stable in ERROR until start_i, which clears both and restarts at S1.
REQ-015 err_code_o SHALL encode 0 = none, 1 = DMI failed, 2 = halt timeout, 3 = cmderr, 4 = abstract-busy timeout, 5 = resume timeout.

Reset
REQ-016 When rst_i = 1 at a clk_i edge, the block SHALL enter IDLE regardless of state, dropping any outstanding request.
REQ-017 Reset values SHALL be: all outputs 0, poll counter 0, state IDLE.

Configuration
REQ-018 With DM_BOOT_SEQ_TIMEOUT_EN defined, each poll loop (S4, S9, S11) SHALL count completed reads and go to ERROR with code 2, 4 or 5 respectively when the count reaches POLL_LIMIT without success.
REQ-019 Without DM_BOOT_SEQ_TIMEOUT_EN, polls SHALL repeat indefinitely, no counter logic SHALL exist, and codes 2, 4 and 5 SHALL never occur.

Verification
REQ-020 Start with an ideal DM model (halt after 3 reads, image_ready_i already 1) -> exact 11-step address/data sequence; 0x04 written with 0x8000_0080; one done_o pulse; error_o = 0.
REQ-021 dmi_req_ready_i held 0 for 5 cycles at S3 -> valid and payload 0x8000_0001 stable throughout; exactly one acceptance.
REQ-022 Response code 3 on S7 twice, then 0 -> 0x04 write issued 3 times, then the sequence continues.
REQ-023 S9 read returns 0x0000_0200 (cmderr = 2) -> error_o = 1, err_code_o = 3, busy_o = 0, no resume write.
REQ-024 With TIMEOUT_EN and POLL_LIMIT = 4, allhalted never set -> exactly 4 reads of 0x11, then err_code_o = 2.
REQ-025 rst_i = 1 during S6 with halted_o = 1 -> next cycle all outputs 0; a new start_i restarts at S1.

Source files
------------

// File: rtl/dm_boot_sequencer.sv
// -----------------------------------------------------------------------------
// dm_boot_sequencer
//
// Purpose:
//   Boots a RISC-V hart through its Debug Module over a DMI request/response
//   link. The sequence is: activate the DM, select the hart, halt it, wait for
//   the memory image, write DPC = BOOT_ADDR with an abstract command, then
//   resume the hart. Only one DMI transaction is in flight at any time.
//
// Parameters:
//   BOOT_ADDR  - value written to the hart's DPC before resume.
//   HARTSEL    - hart index placed in dmcontrol.hartsello[25:16].
//   POLL_LIMIT - maximum reads per poll loop. Used only when the optional
//                poll timeout is built in.
//
// Optional feature macro:
//   DM_BOOT_SEQ_TIMEOUT_EN - when defined, each poll loop (halt, abstract
//   busy, resume ack) gives up after POLL_LIMIT completed reads and reports
//   error code 2, 4 or 5. When undefined, polls repeat indefinitely and no
//   counter is built.
//
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset.
//   start_i               - one-cycle start pulse (ignored while busy).
//   image_ready_i         - memory image has been loaded.
//   dmi_req_*             - DMI request channel (valid/ready, addr, op, data).
//   dmi_resp_*            - DMI response channel (valid/ready, data, code).
//   busy_o                - sequence in progress.
//   halted_o              - hart confirmed halted, waiting for the image.
//   done_o                - one-cycle completion pulse.
//   error_o, err_code_o   - sticky error flag and cause
//                           (0 none, 1 DMI failed, 2 halt timeout, 3 cmderr,
//                            4 abstract-busy timeout, 5 resume timeout).
// -----------------------------------------------------------------------------
module dm_boot_sequencer #(
  parameter logic [31:0] BOOT_ADDR  = 32'h8000_0080,
  parameter logic [9:0]  HARTSEL    = 10'd0,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        image_ready_i,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [6:0]  dmi_req_addr_o,
  output logic [1:0]  dmi_req_op_o,
  output logic [31:0] dmi_req_data_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [31:0] dmi_resp_data_i,
  input  logic [1:0]  dmi_resp_i,
  output logic        busy_o,
  output logic        halted_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  err_code_o
);

  // Top-level states
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_RESP = 3'd2;
  localparam logic [2:0] ST_WAIT_IMG  = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_ERROR     = 3'd5;

  // Sequence steps
  localparam logic [3:0] STEP_S1  = 4'd1;
  localparam logic [3:0] STEP_S2  = 4'd2;
  localparam logic [3:0] STEP_S3  = 4'd3;
  localparam logic [3:0] STEP_S4  = 4'd4;
  localparam logic [3:0] STEP_S5  = 4'd5;
  localparam logic [3:0] STEP_S6  = 4'd6;
  localparam logic [3:0] STEP_S7  = 4'd7;
  localparam logic [3:0] STEP_S8  = 4'd8;
  localparam logic [3:0] STEP_S9  = 4'd9;
  localparam logic [3:0] STEP_S10 = 4'd10;
  localparam logic [3:0] STEP_S11 = 4'd11;

  // DM register addresses and DMI encodings
  localparam logic [6:0] ADDR_DATA0      = 7'h04;
  localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
  localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
  localparam logic [6:0] ADDR_COMMAND    = 7'h17;
  localparam logic [1:0] OP_READ         = 2'd1;
  localparam logic [1:0] OP_WRITE        = 2'd2;
  localparam logic [1:0] RESP_OK         = 2'd0;
  localparam logic [1:0] RESP_BUSY       = 2'd3;

  // Error codes
  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_DMI_FAILED   = 3'd1;
  localparam logic [2:0] ERR_HALT_TMO     = 3'd2;
  localparam logic [2:0] ERR_CMDERR       = 3'd3;
  localparam logic [2:0] ERR_ABS_BUSY_TMO = 3'd4;
  localparam logic [2:0] ERR_RESUME_TMO   = 3'd5;

  // dmcontrol building blocks: dmactive, hartsello field, haltreq, resumereq
  localparam logic [31:0] HS         = {6'd0, HARTSEL, 16'd0};
  localparam logic [31:0] DMACTIVE   = 32'h0000_0001;
  localparam logic [31:0] HALTREQ    = 32'h8000_0000;
  localparam logic [31:0] RESUMEREQ  = 32'h4000_0000;
  // Abstract command: access register, 32-bit, transfer, write, regno = DPC
  localparam logic [31:0] CMD_WR_DPC = 32'h0023_07B1;

  if (POLL_LIMIT < 1) begin : g_bad_poll_limit
    $error("dm_boot_sequencer: POLL_LIMIT must be at least 1");
  end

  logic [2:0] state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [2:0] err_code_q, err_code_d;

  // An OK poll read whose success condition was not met
  logic       poll_miss;
  logic       poll_expired;
  logic [2:0] poll_tmo_code;
  logic       resp_fire;

  assign resp_fire = (state_q == ST_WAIT_RESP) && dmi_resp_valid_i;

  // Only a few status bits are inspected; the rest of the word is don't-care.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{dmi_resp_data_i[31:18], dmi_resp_data_i[16:13],
                              dmi_resp_data_i[11], dmi_resp_data_i[7:0]};

  always_comb begin
    poll_tmo_code = ERR_RESUME_TMO;
    case (step_q)
      STEP_S4: poll_tmo_code = ERR_HALT_TMO;
      STEP_S9: poll_tmo_code = ERR_ABS_BUSY_TMO;
      default: poll_tmo_code = ERR_RESUME_TMO;
    endcase
  end

`ifdef DM_BOOT_SEQ_TIMEOUT_EN
  localparam int CNT_W = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  logic [CNT_W-1:0] poll_cnt_q, poll_cnt_d;

  // The count holds completed-but-unsuccessful reads of the current poll;
  // the read that would make it POLL_LIMIT ends the loop instead.
  assign poll_expired = (poll_cnt_q == CNT_W'(POLL_LIMIT - 1));

  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (state_q == ST_IDLE || state_q == ST_ERROR) begin
      poll_cnt_d = '0;
    end else if (resp_fire && dmi_resp_i == RESP_OK) begin
      poll_cnt_d = poll_miss ? poll_cnt_q + CNT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end
`else
  assign poll_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    err_code_d = err_code_q;
    poll_miss  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ISSUE;
          step_d  = STEP_S1;
        end
      end

      ST_ISSUE: begin
        if (dmi_req_ready_i) begin
          state_d = ST_WAIT_RESP;
        end
      end

      ST_WAIT_RESP: begin
        if (dmi_resp_valid_i) begin
          if (dmi_resp_i == RESP_BUSY) begin
            // DM not ready: replay the identical request
            state_d = ST_ISSUE;
          end else if (dmi_resp_i != RESP_OK) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_DMI_FAILED;
          end else begin
            state_d = ST_ISSUE;
            case (step_q)
              STEP_S4: begin
                if (dmi_resp_data_i[9]) step_d = STEP_S5;
                else                    poll_miss = 1'b1;
              end
              STEP_S5: begin
                // Skip the wait state entirely if the image is already there
                if (image_ready_i) begin
                  step_d = STEP_S7;
                end else begin
                  state_d = ST_WAIT_IMG;
                  step_d  = STEP_S6;
                end
              end
              STEP_S9: begin
                if (dmi_resp_data_i[12]) begin
                  poll_miss = 1'b1;
                end else if (dmi_resp_data_i[10:8] != 3'd0) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_CMDERR;
                end else begin
                  step_d = STEP_S10;
                end
              end
              STEP_S11: begin
                if (dmi_resp_data_i[17]) state_d = ST_DONE;
                else                     poll_miss = 1'b1;
              end
              default: step_d = step_q + 4'd1;
            endcase

            if (poll_miss && poll_expired) begin
              state_d    = ST_ERROR;
              err_code_d = poll_tmo_code;
            end
          end
        end
      end

      ST_WAIT_IMG: begin
        if (image_ready_i) begin
          state_d = ST_ISSUE;
          step_d  = STEP_S7;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_ERROR: begin
        if (start_i) begin
          state_d    = ST_ISSUE;
          step_d     = STEP_S1;
          err_code_d = ERR_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      step_q     <= 4'd0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      err_code_q <= err_code_d;
    end
  end

  // Request payload is a pure decode of step_q, so it cannot change while
  // the request waits for ready.
  always_comb begin
    dmi_req_addr_o = 7'd0;
    dmi_req_op_o   = 2'd0;
    dmi_req_data_o = 32'd0;
    if (state_q == ST_ISSUE) begin
      case (step_q)
        STEP_S1: begin
          dmi_req_addr_o = ADDR_DMCONTROL;
          dmi_req_op_o   = OP_WRITE;
          dmi_req_data_o = DMACTIVE;
        end
        STEP_S2, STEP_S5: begin
          dmi_req_addr_o = ADDR_DMCONTROL;
          dmi_req_op_o   = OP_WRITE;
          dmi_req_data_o = HS | DMACTIVE;
        end
        STEP_S3: begin
          dmi_req_addr_o = ADDR_DMCONTROL;
          dmi_req_op_o   = OP_WRITE;
          dmi_req_data_o = HALTREQ | HS | DMACTIVE;
        end
        STEP_S4, STEP_S11: begin
          dmi_req_addr_o = ADDR_DMSTATUS;
          dmi_req_op_o   = OP_READ;
        end
        STEP_S7: begin
          dmi_req_addr_o = ADDR_DATA0;
          dmi_req_op_o   = OP_WRITE;
          dmi_req_data_o = BOOT_ADDR;
        end
        STEP_S8: begin
          dmi_req_addr_o = ADDR_COMMAND;
          dmi_req_op_o   = OP_WRITE;
          dmi_req_data_o = CMD_WR_DPC;
        end
        STEP_S9: begin
          dmi_req_addr_o = ADDR_ABSTRACTCS;
          dmi_req_op_o   = OP_READ;
        end
        STEP_S10: begin
          dmi_req_addr_o = ADDR_DMCONTROL;
          dmi_req_op_o   = OP_WRITE;
          dmi_req_data_o = RESUMEREQ | HS | DMACTIVE;
        end
        default: begin
          dmi_req_addr_o = 7'd0;
          dmi_req_op_o   = 2'd0;
          dmi_req_data_o = 32'd0;
        end
      endcase
    end
  end

  assign dmi_req_valid_o  = (state_q == ST_ISSUE);
  assign dmi_resp_ready_o = (state_q == ST_WAIT_RESP);
  assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign halted_o         = (state_q == ST_WAIT_IMG) ||
                            (((state_q == ST_ISSUE) || (state_q == ST_WAIT_RESP)) &&
                             (step_q == STEP_S5));
  assign done_o           = (state_q == ST_DONE);
  assign error_o          = (state_q == ST_ERROR);
  assign err_code_o       = err_code_q;

endmodule

// File: tb/tb_dm_boot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dm_boot_sequencer
//
// Directed bench for dm_boot_sequencer. A small Debug Module model answers
// DMI requests one cycle after acceptance and logs every accepted request;
// the directed steps in the main initial block configure the model, run a
// boot sequence and compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_dm_boot_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        image_ready_i = 1'b1;
  logic        dmi_req_valid_o;
  logic        dmi_req_ready_i = 1'b0;
  logic [6:0]  dmi_req_addr_o;
  logic [1:0]  dmi_req_op_o;
  logic [31:0] dmi_req_data_o;
  logic        dmi_resp_valid_i = 1'b0;
  logic        dmi_resp_ready_o;
  logic [31:0] dmi_resp_data_i = 32'd0;
  logic [1:0]  dmi_resp_i = 2'd0;
  logic        busy_o;
  logic        halted_o;
  logic        done_o;
  logic        error_o;
  logic [2:0]  err_code_o;

  dm_boot_sequencer #(
    .BOOT_ADDR (32'h8000_0080),
    .HARTSEL   (10'd0),
    .POLL_LIMIT(4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .image_ready_i   (image_ready_i),
    .dmi_req_valid_o (dmi_req_valid_o),
    .dmi_req_ready_i (dmi_req_ready_i),
    .dmi_req_addr_o  (dmi_req_addr_o),
    .dmi_req_op_o    (dmi_req_op_o),
    .dmi_req_data_o  (dmi_req_data_o),
    .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o),
    .dmi_resp_data_i (dmi_resp_data_i),
    .dmi_resp_i      (dmi_resp_i),
    .busy_o          (busy_o),
    .halted_o        (halted_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .err_code_o      (err_code_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- DM model state and configuration ----------------
  logic        pending = 1'b0;
  logic [6:0]  cur_addr = 7'd0;
  logic [1:0]  cur_op = 2'd0;
  logic [31:0] cur_data = 32'd0;
  logic        resume_seen = 1'b0;
  int          rd11 = 0;
  int          done_cnt = 0;
  int          stall_cycles = 0;
  int          stall_bad = 0;
  int          viol = 0;
  logic [40:0] log_q[$];

  int          halt_after = 3;
  int          stall_left = 0;
  int          busy_s7_left = 0;
  logic        fail_s8 = 1'b0;
  logic [31:0] s9_data = 32'd0;

  function automatic logic [40:0] ent(input logic [6:0] a, input logic [1:0] o,
                                      input logic [31:0] d);
    return {a, o, d};
  endfunction

  function automatic int count_log(input logic [40:0] key);
    int n = 0;
    foreach (log_q[i]) if (log_q[i] === key) n++;
    return n;
  endfunction

  // Responds on the negedge after acceptance; the DUT consumes on the next posedge.
  always @(negedge clk) begin
    if (dmi_resp_valid_i) dmi_resp_valid_i = 1'b0;
    if (pending) begin
      pending = 1'b0;
      if (dmi_req_valid_o) viol++;
      dmi_resp_i      = 2'd0;
      dmi_resp_data_i = 32'd0;
      case (cur_addr)
        7'h11: begin
          rd11++;
          if (resume_seen)           dmi_resp_data_i = 32'h0002_0000;
          else if (rd11 >= halt_after) dmi_resp_data_i = 32'h0000_0200;
        end
        7'h16: dmi_resp_data_i = s9_data;
        7'h04: if (busy_s7_left > 0) begin dmi_resp_i = 2'd3; busy_s7_left--; end
        7'h17: if (fail_s8) dmi_resp_i = 2'd2;
        7'h10: if (cur_data[30]) resume_seen = 1'b1;
        default: ;
      endcase
      dmi_resp_valid_i = 1'b1;
      $display("txn addr=0x%02h op=%0d wdata=0x%08h resp=%0d rdata=0x%08h",
               cur_addr, cur_op, cur_data, dmi_resp_i, dmi_resp_data_i);
    end
    if (done_o) done_cnt++;
    dmi_req_ready_i = 1'b0;
    if (!rst_i && dmi_req_valid_o) begin
      if (stall_left > 0 && dmi_req_addr_o == 7'h10 && dmi_req_data_o[31]) begin
        stall_left--;
        stall_cycles++;
        if ({dmi_req_op_o, dmi_req_data_o} !== {2'd2, 32'h8000_0001}) stall_bad++;
      end else begin
        dmi_req_ready_i = 1'b1;
        cur_addr = dmi_req_addr_o;
        cur_op   = dmi_req_op_o;
        cur_data = dmi_req_data_o;
        pending  = 1'b1;
        log_q.push_back(ent(dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    rd11 = 0; done_cnt = 0; stall_cycles = 0; stall_bad = 0;
    resume_seen = 1'b0; log_q.delete();
    halt_after = 3; stall_left = 0; busy_s7_left = 0; fail_s8 = 1'b0; s9_data = 32'd0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // which = 0: wait for done_o or error_o; which = 1: wait for halted_o
  task automatic wait_sig(input string tag, input int which, input int budget);
    int n = 0;
    while (n < budget && !((which == 0) ? (done_o || error_o) : halted_o)) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < budget) else begin
      failures++;
      $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, n, budget);
    end
    if (which == 0) repeat (2) @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_op_o, dmi_req_data_o,
                dmi_resp_ready_o, busy_o, halted_o, done_o, error_o, err_code_o});
  endfunction

  logic [40:0] exp_ideal [12];

  initial begin
    exp_ideal[0]  = ent(7'h10, 2'd2, 32'h0000_0001);
    exp_ideal[1]  = ent(7'h10, 2'd2, 32'h0000_0001);
    exp_ideal[2]  = ent(7'h10, 2'd2, 32'h8000_0001);
    exp_ideal[3]  = ent(7'h11, 2'd1, 32'h0000_0000);
    exp_ideal[4]  = ent(7'h11, 2'd1, 32'h0000_0000);
    exp_ideal[5]  = ent(7'h11, 2'd1, 32'h0000_0000);
    exp_ideal[6]  = ent(7'h10, 2'd2, 32'h0000_0001);
    exp_ideal[7]  = ent(7'h04, 2'd2, 32'h8000_0080);
    exp_ideal[8]  = ent(7'h17, 2'd2, 32'h0023_07B1);
    exp_ideal[9]  = ent(7'h16, 2'd1, 32'h0000_0000);
    exp_ideal[10] = ent(7'h10, 2'd2, 32'h4000_0001);
    exp_ideal[11] = ent(7'h11, 2'd1, 32'h0000_0000);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst_i = 1'b0;
    clear_model();
    @(negedge clk);

    // Ideal DM: halted after 3 reads, image already present
    pulse_start();
    wait_sig("ideal_end", 0, 500);
    check("ideal_log_len", 64'(log_q.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < log_q.size()) check($sformatf("ideal_txn%0d", i), 64'(log_q[i]), 64'(exp_ideal[i]));
    end
    check("ideal_done_pulses", 64'(done_cnt), 64'd1);
    check("ideal_error", 64'(error_o), 64'd0);
    check("ideal_busy_after", 64'(busy_o), 64'd0);

    // Request held off for 5 cycles at the halt request
    do_reset();
    clear_model();
    stall_left = 5;
    pulse_start();
    wait_sig("stall_end", 0, 500);
    check("stall_cycles", 64'(stall_cycles), 64'd5);
    check("stall_payload_changes", 64'(stall_bad), 64'd0);
    check("stall_accepts", 64'(count_log(ent(7'h10, 2'd2, 32'h8000_0001))), 64'd1);
    check("stall_done", 64'(done_cnt), 64'd1);

    // Busy response twice on the DATA0 write
    do_reset();
    clear_model();
    busy_s7_left = 2;
    pulse_start();
    wait_sig("busy_end", 0, 500);
    check("busy_data0_writes", 64'(count_log(ent(7'h04, 2'd2, 32'h8000_0080))), 64'd3);
    check("busy_log_len", 64'(log_q.size()), 64'd14);
    check("busy_done", 64'(done_cnt), 64'd1);

    // cmderr reported by abstractcs
    do_reset();
    clear_model();
    s9_data = 32'h0000_0200;
    pulse_start();
    wait_sig("cmderr_end", 0, 500);
    check("cmderr_error", 64'(error_o), 64'd1);
    check("cmderr_code", 64'(err_code_o), 64'd3);
    check("cmderr_busy", 64'(busy_o), 64'd0);
    check("cmderr_no_resume", 64'(count_log(ent(7'h10, 2'd2, 32'h4000_0001))), 64'd0);
    repeat (5) @(negedge clk);
    check("cmderr_sticky", 64'({error_o, err_code_o}), 64'({1'b1, 3'd3}));
    // start from ERROR clears the error and restarts at the first step
    s9_data = 32'd0;
    pulse_start();
    check("restart_clears", 64'({error_o, err_code_o}), 64'd0);
    check("restart_first_req", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o}),
          64'({1'b1, 7'h10, 32'h0000_0001}));
    wait_sig("restart_end", 0, 500);
    check("restart_done", 64'(done_cnt), 64'd1);

    // DMI failure on the command write
    do_reset();
    clear_model();
    fail_s8 = 1'b1;
    pulse_start();
    wait_sig("fail_end", 0, 500);
    check("fail_code", 64'({error_o, err_code_o}), 64'({1'b1, 3'd1}));

    // Image not ready: park in the halted wait, then reset from there
    do_reset();
    clear_model();
    image_ready_i = 1'b0;
    pulse_start();
    wait_sig("img_halted", 1, 500);
    repeat (10) @(negedge clk);
    check("img_wait_state", 64'({halted_o, busy_o, dmi_req_valid_o}), 64'({1'b1, 1'b1, 1'b0}));
    check("img_no_data0", 64'(count_log(ent(7'h04, 2'd2, 32'h8000_0080))), 64'd0);
    check("img_log_len", 64'(log_q.size()), 64'd7);
    rst_i = 1'b1;
    @(negedge clk);
    check("img_reset_outputs", all_outs(), 64'd0);
    rst_i = 1'b0;
    image_ready_i = 1'b1;
    clear_model();
    @(negedge clk);
    pulse_start();
    check("img_restart_req", 64'({dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o}),
          64'({1'b1, 7'h10, 32'h0000_0001}));
    wait_sig("img_restart_end", 0, 500);
    check("img_restart_done", 64'(done_cnt), 64'd1);

`ifdef DM_BOOT_SEQ_TIMEOUT_EN
    // Hart never halts: POLL_LIMIT = 4 reads, then halt timeout
    do_reset();
    clear_model();
    halt_after = 1000000;
    pulse_start();
    wait_sig("tmo_end", 0, 500);
    check("tmo_reads", 64'(rd11), 64'd4);
    check("tmo_code", 64'({error_o, err_code_o}), 64'({1'b1, 3'd2}));
`endif

    check("valid_drop_after_accept", 64'(viol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
